// File: rtl/abs_diff_sweep_ctrl.sv
// Exhaustive sweep controller for a 4-bit approximate abs-diff unit: walks all
// 256 operand pairs and accumulates error count, error sum and worst-case pair.
module abs_diff_sweep_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [3:0]  dut_a,
    output logic [3:0]  dut_b,
    input  logic [3:0]  dut_y,
    output logic        busy,
    output logic        done,
    output logic        result_valid,
    output logic [8:0]  err_count,
    output logic [11:0] sum_err,
    output logic [3:0]  max_err,
    output logic [3:0]  wce_a,
    output logic [3:0]  wce_b
);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic        drain_q, drain_d;

    logic        s1_valid_q, s1_valid_d;
    logic [3:0]  s1_a_q, s1_a_d;
    logic [3:0]  s1_b_q, s1_b_d;
    logic [3:0]  s1_y_q, s1_y_d;
    logic [3:0]  s1_exact_q, s1_exact_d;

    logic [8:0]  err_count_q, err_count_d;
    logic [11:0] sum_err_q, sum_err_d;
    logic [3:0]  max_err_q, max_err_d;
    logic [3:0]  wce_a_q, wce_a_d;
    logic [3:0]  wce_b_q, wce_b_d;
    logic        result_valid_q, result_valid_d;

    logic [3:0]  err;

    // Operands are the index register itself, so they hold whenever idx holds.
    assign dut_a        = idx_q[3:0];
    assign dut_b        = idx_q[7:4];
    assign busy         = (state_q == SWEEP) || (state_q == DRAIN);
    assign done         = (state_q == DONE);
    assign result_valid = result_valid_q;
    assign err_count    = err_count_q;
    assign sum_err      = sum_err_q;
    assign max_err      = max_err_q;
    assign wce_a        = wce_a_q;
    assign wce_b        = wce_b_q;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        drain_d        = drain_q;
        s1_valid_d     = 1'b0;
        s1_a_d         = dut_a;
        s1_b_d         = dut_b;
        s1_y_d         = dut_y;
        s1_exact_d     = (dut_a >= dut_b) ? (dut_a - dut_b) : (dut_b - dut_a);
        err_count_d    = err_count_q;
        sum_err_d      = sum_err_q;
        max_err_d      = max_err_q;
        wce_a_d        = wce_a_q;
        wce_b_d        = wce_b_q;
        result_valid_d = result_valid_q;

        err = (s1_exact_q >= s1_y_q) ? (s1_exact_q - s1_y_q) : (s1_y_q - s1_exact_q);
        if (s1_valid_q) begin
            sum_err_d = sum_err_q + 12'(err);
            if (err != '0) begin
                err_count_d = err_count_q + 9'd1;
            end
            // Strict compare keeps the first worst-case pair in sweep order.
            if (err > max_err_q) begin
                max_err_d = err;
                wce_a_d   = s1_a_q;
                wce_b_d   = s1_b_q;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d        = SWEEP;
                    idx_d          = '0;
                    err_count_d    = '0;
                    sum_err_d      = '0;
                    max_err_d      = '0;
                    wce_a_d        = '0;
                    wce_b_d        = '0;
                    result_valid_d = 1'b0;
                end
            end
            SWEEP: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    s1_valid_d = 1'b1;
                    if (idx_q == 8'd255) begin
                        state_d = DRAIN;
                        drain_d = 1'b0;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (drain_q) begin
                    state_d        = DONE;
                    result_valid_d = 1'b1;
                end else begin
                    drain_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            drain_q        <= 1'b0;
            s1_valid_q     <= 1'b0;
            s1_a_q         <= '0;
            s1_b_q         <= '0;
            s1_y_q         <= '0;
            s1_exact_q     <= '0;
            err_count_q    <= '0;
            sum_err_q      <= '0;
            max_err_q      <= '0;
            wce_a_q        <= '0;
            wce_b_q        <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            drain_q        <= drain_d;
            s1_valid_q     <= s1_valid_d;
            s1_a_q         <= s1_a_d;
            s1_b_q         <= s1_b_d;
            s1_y_q         <= s1_y_d;
            s1_exact_q     <= s1_exact_d;
            err_count_q    <= err_count_d;
            sum_err_q      <= sum_err_d;
            max_err_q      <= max_err_d;
            wce_a_q        <= wce_a_d;
            wce_b_q        <= wce_b_d;
            result_valid_q <= result_valid_d;
        end
    end

endmodule

// File: tb/tb_abs_diff_sweep_ctrl.sv
// Randomized bench for abs_diff_sweep_ctrl: a cycle-count reference model plus a
// per-cycle compare process, with literal totals for the fixed unit behaviours.
module tb_abs_diff_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  dut_a, dut_b, dut_y;
    logic        busy, done, result_valid;
    logic [8:0]  err_count;
    logic [11:0] sum_err;
    logic [3:0]  max_err, wce_a, wce_b;

    int checks = 0;
    int errors = 0;

    // 0: exact unit, 1: tied to 0, 2: tied to 15, 3: random lookup table
    int mode = 0;
    int lut [256];

    always #5 clk = ~clk;

    abs_diff_sweep_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .dut_a(dut_a), .dut_b(dut_b), .dut_y(dut_y),
        .busy(busy), .done(done), .result_valid(result_valid),
        .err_count(err_count), .sum_err(sum_err), .max_err(max_err),
        .wce_a(wce_a), .wce_b(wce_b)
    );

    function automatic int absd(input int x, input int y);
        return (x >= y) ? x - y : y - x;
    endfunction

    function automatic int unit_y(input int a, input int b);
        case (mode)
            0:       return absd(a, b);
            1:       return 0;
            2:       return 15;
            default: return lut[b * 16 + a];
        endcase
    endfunction

    always_comb dut_y = 4'(unit_y(int'(dut_a), int'(dut_b)));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected totals for a whole sweep under the current unit behaviour.
    int exp_cnt, exp_sum, exp_max, exp_wa, exp_wb;
    task automatic model_sweep();
        int e;
        exp_cnt = 0; exp_sum = 0; exp_max = 0; exp_wa = 0; exp_wb = 0;
        for (int i = 0; i < 256; i++) begin
            e = absd(absd(i % 16, i / 16), unit_y(i % 16, i / 16));
            exp_sum += e;
            if (e != 0) exp_cnt++;
            if (e > exp_max) begin exp_max = e; exp_wa = i % 16; exp_wb = i / 16; end
        end
    endtask

    // Reference timeline: m_cyc counts cycles since start acceptance, 0 when idle.
    int m_cyc = 0;
    int m_a = 0, m_b = 0;
    bit m_rv = 0, m_init = 0, m_zero = 0;
    always @(posedge clk) begin
        if (rst) begin
            m_cyc = 0; m_rv = 0; m_a = 0; m_b = 0; m_init = 1; m_zero = 1;
        end else if (m_cyc == 0) begin
            if (start) begin m_cyc = 1; m_rv = 0; m_zero = 0; end
        end else if (abort && m_cyc <= 258) begin
            m_cyc = 0;
        end else if (m_cyc == 259) begin
            m_cyc = 0;
        end else begin
            m_cyc++;
        end
        if (m_cyc == 259) m_rv = 1;
        if (m_cyc >= 1 && m_cyc <= 256) begin
            m_a = (m_cyc - 1) % 16;
            m_b = (m_cyc - 1) / 16;
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("dut_a", int'(dut_a), m_a);
            chk("dut_b", int'(dut_b), m_b);
            chk("busy", int'(busy), int'(m_cyc >= 1 && m_cyc <= 258));
            chk("done", int'(done), int'(m_cyc == 259));
            chk("result_valid", int'(result_valid), int'(m_rv));
            if (m_cyc == 1 || m_zero) begin
                chk("clr_err_count", int'(err_count), 0);
                chk("clr_sum_err", int'(sum_err), 0);
                chk("clr_max_err", int'(max_err), 0);
                chk("clr_wce", int'({wce_b, wce_a}), 0);
            end
            if (m_cyc == 259) begin
                chk("err_count", int'(err_count), exp_cnt);
                chk("sum_err", int'(sum_err), exp_sum);
                chk("max_err", int'(max_err), exp_max);
                chk("wce_a", int'(wce_a), exp_wa);
                chk("wce_b", int'(wce_b), exp_wb);
            end
        end
    end

    // Inputs change 1 time unit after a rising edge; cur is the cycle number.
    int cur = 0;
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cur++;
        end
    endtask

    task automatic go();
        model_sweep();
        start = 1'b1;
        step(1);
        start = 1'b0;
        cur = 1;
    endtask

    task automatic pulse_at(input int cyc, input bit is_abort, input bit is_start);
        step(cyc - cur);
        if (is_abort) abort = 1'b1;
        if (is_start) start = 1'b1;
        step(1);
        abort = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 300) begin step(1); n++; end
        chk("done_reached", int'(done), 1);
        chk("done_cycle", cur, 259);
    endtask

    task automatic chk_totals(input int c, input int s, input int m, input int wa, input int wb);
        chk("lit_err_count", int'(err_count), c);
        chk("lit_sum_err", int'(sum_err), s);
        chk("lit_max_err", int'(max_err), m);
        chk("lit_wce_a", int'(wce_a), wa);
        chk("lit_wce_b", int'(wce_b), wb);
        chk("lit_result_valid", int'(result_valid), 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) lut[i] = int'($urandom_range(15, 0));
        @(posedge clk); #1;
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(4);

        mode = 0; go(); wait_done();
        chk_totals(0, 0, 0, 0, 0);
        step(3);

        // start re-pulsed mid-sweep and in the last drain cycle is ignored
        mode = 1; go();
        pulse_at(50, 0, 1);
        pulse_at(258, 0, 1);
        cur = 259;
        chk("done_after_repulse", int'(done), 1);
        chk_totals(240, 1360, 15, 15, 0);
        step(3);

        // start and abort together in IDLE: start wins; abort during DONE ignored
        mode = 2;
        abort = 1'b1;
        go();
        abort = 1'b0;
        pulse_at(259, 1, 0);
        step(2);
        chk("rv_after_done_abort", int'(result_valid), 1);
        chk("count_after_done_abort", int'(err_count), 254);
        chk_totals(254, 2480, 15, 0, 0);

        // abort in cycle 100
        mode = 1; go();
        pulse_at(100, 1, 0);
        chk("busy_after_abort", int'(busy), 0);
        step(5);
        chk("rv_after_abort", int'(result_valid), 0);

        mode = 3; go(); wait_done();
        step(2);

        // reset in cycle 120, then a fresh exact sweep
        mode = 0; go();
        step(119);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_dut_a", int'(dut_a), 0);
        step(5);
        go(); wait_done();
        chk_totals(0, 0, 0, 0, 0);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 256; i++) lut[i] = int'($urandom_range(15, 0));
            step(int'($urandom_range(5, 1)));
            mode = 3; go(); wait_done();
        end
        step(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
